// File: rtl/picorv32_pcpi_fp_hub.sv
// PCPI dispatch hub: decodes custom-0 instructions by funct7, hands registered
// operands to one floating-point coprocessor and returns its result to the CPU.
module picorv32_pcpi_fp_hub #(
  parameter int NUM_UNITS = 4,
  parameter logic [NUM_UNITS*7-1:0] FUNCT7_LIST = {7'h03, 7'h02, 7'h01, 7'h00},
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pcpi_valid,
  input  logic [31:0]               pcpi_insn,
  input  logic [31:0]               pcpi_rs1,
  input  logic [31:0]               pcpi_rs2,
  output logic                      pcpi_wr,
  output logic [31:0]               pcpi_rd,
  output logic                      pcpi_wait,
  output logic                      pcpi_ready,
  output logic [NUM_UNITS-1:0]      u_valid,
  output logic [31:0]               u_insn,
  output logic [31:0]               u_rs1,
  output logic [31:0]               u_rs2,
  input  logic [NUM_UNITS*32-1:0]   u_rd,
  input  logic [NUM_UNITS-1:0]      u_wr,
  input  logic [NUM_UNITS-1:0]      u_ready,
  output logic [7:0]                timeout_count
);

  localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [6:0] CUSTOM0 = 7'b0001011;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DRAIN} state_t;

  state_t state_q, state_d;

  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [NUM_UNITS-1:0] uValid_q, uValid_d;
  logic [31:0]          uInsn_q, uInsn_d;
  logic [31:0]          uRs1_q, uRs1_d;
  logic [31:0]          uRs2_q, uRs2_d;
  logic                 pcpiWait_q, pcpiWait_d;
  logic                 pcpiReady_q, pcpiReady_d;
  logic                 pcpiWr_q, pcpiWr_d;
  logic [31:0]          pcpiRd_q, pcpiRd_d;
  logic [7:0]           timeoutCount_q, timeoutCount_d;

  logic                 match;
  logic [SEL_W-1:0]     matchSel;
  logic                 selReady;
  logic                 selWr;
  logic [31:0]          selRd;
  logic                 timerLast;

  // Scan from the top index down so the lowest matching unit ends up selected.
  always_comb begin
    match    = 1'b0;
    matchSel = '0;
    if (pcpi_insn[6:0] == CUSTOM0) begin
      for (int i = NUM_UNITS - 1; i >= 0; i--) begin
        if (pcpi_insn[31:25] == FUNCT7_LIST[7*i +: 7]) begin
          match    = 1'b1;
          matchSel = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    selReady = 1'b0;
    selWr    = 1'b0;
    selRd    = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        selReady = u_ready[i];
        selWr    = u_wr[i];
        selRd    = u_rd[32*i +: 32];
      end
    end
  end

  assign timerLast = (timer_q == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pcpi_valid && match) state_d = ISSUE;
      ISSUE: begin
        if (selReady)       state_d = RESP;
        else if (timerLast) state_d = DRAIN;
      end
      RESP:    state_d = DRAIN;
      DRAIN:   if (!pcpi_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A ready arriving on the timer's last cycle still wins over the timeout.
  always_comb begin
    sel_d          = sel_q;
    timer_d        = timer_q;
    uValid_d       = uValid_q;
    uInsn_d        = uInsn_q;
    uRs1_d         = uRs1_q;
    uRs2_d         = uRs2_q;
    pcpiWait_d     = pcpiWait_q;
    pcpiReady_d    = 1'b0;
    pcpiWr_d       = 1'b0;
    pcpiRd_d       = pcpiRd_q;
    timeoutCount_d = timeoutCount_q;
    case (state_q)
      IDLE: begin
        if (pcpi_valid && match) begin
          sel_d      = matchSel;
          timer_d    = '0;
          uValid_d   = NUM_UNITS'(1) << matchSel;
          uInsn_d    = pcpi_insn;
          uRs1_d     = pcpi_rs1;
          uRs2_d     = pcpi_rs2;
          pcpiWait_d = 1'b1;
        end
      end
      ISSUE: begin
        timer_d = timer_q + TIMER_W'(1);
        if (selReady) begin
          pcpiRd_d    = selRd;
          pcpiWr_d    = selWr;
          pcpiReady_d = 1'b1;
          uValid_d    = '0;
          pcpiWait_d  = 1'b0;
        end else if (timerLast) begin
          uValid_d   = '0;
          pcpiWait_d = 1'b0;
          if (timeoutCount_q != 8'hFF) timeoutCount_d = timeoutCount_q + 8'd1;
        end
      end
      default: begin
        uValid_d   = '0;
        pcpiWait_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q          <= '0;
      timer_q        <= '0;
      uValid_q       <= '0;
      uInsn_q        <= '0;
      uRs1_q         <= '0;
      uRs2_q         <= '0;
      pcpiWait_q     <= 1'b0;
      pcpiReady_q    <= 1'b0;
      pcpiWr_q       <= 1'b0;
      pcpiRd_q       <= '0;
      timeoutCount_q <= '0;
    end else begin
      sel_q          <= sel_d;
      timer_q        <= timer_d;
      uValid_q       <= uValid_d;
      uInsn_q        <= uInsn_d;
      uRs1_q         <= uRs1_d;
      uRs2_q         <= uRs2_d;
      pcpiWait_q     <= pcpiWait_d;
      pcpiReady_q    <= pcpiReady_d;
      pcpiWr_q       <= pcpiWr_d;
      pcpiRd_q       <= pcpiRd_d;
      timeoutCount_q <= timeoutCount_d;
    end
  end

  assign pcpi_wr       = pcpiWr_q;
  assign pcpi_rd       = pcpiRd_q;
  assign pcpi_wait     = pcpiWait_q;
  assign pcpi_ready    = pcpiReady_q;
  assign u_valid       = uValid_q;
  assign u_insn        = uInsn_q;
  assign u_rs1         = uRs1_q;
  assign u_rs2         = uRs2_q;
  assign timeout_count = timeoutCount_q;

endmodule

// File: tb/tb_picorv32_pcpi_fp_hub.sv
// Bench for picorv32_pcpi_fp_hub: behavioural unit stubs, a result scoreboard,
// a vector table and hand-built timeout / stray-ready / mid-issue reset sequences.
module tb_picorv32_pcpi_fp_hub;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          unit;
    int          lat;
    logic [31:0] data;
    logic        wr;
    logic [31:0] expValid;
    logic        expMatch;
    logic [31:0] expRd;
    logic        expWr;
    int          expLat;
  } vec_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        wr;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         pcpi_valid;
  logic [31:0]  pcpi_insn;
  logic [31:0]  pcpi_rs1;
  logic [31:0]  pcpi_rs2;
  logic         pcpi_wr;
  logic [31:0]  pcpi_rd;
  logic         pcpi_wait;
  logic         pcpi_ready;
  logic [3:0]   u_valid;
  logic [31:0]  u_insn;
  logic [31:0]  u_rs1;
  logic [31:0]  u_rs2;
  logic [127:0] u_rd;
  logic [3:0]   u_wr;
  logic [3:0]   u_ready;
  logic [7:0]   timeout_count;

  logic [3:0]   modelReady;
  logic [3:0]   forceReady;
  int           lat[4];
  int           cnt[4];
  logic [31:0]  unitData[4];
  bit           unitWr[4];
  bit           neverReady[4];
  bit           useFpsub[4];

  exp_t         sbQ[$];
  int           testsRun;
  int           testsFailed;

  // funct7 0x02 (fpsub) is placed on unit 1, 0x01 moves to unit 2
  picorv32_pcpi_fp_hub #(
    .NUM_UNITS(4),
    .FUNCT7_LIST({7'h03, 7'h01, 7'h02, 7'h00}),
    .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pcpi_valid(pcpi_valid),
    .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1),
    .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr),
    .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait),
    .pcpi_ready(pcpi_ready),
    .u_valid(u_valid),
    .u_insn(u_insn),
    .u_rs1(u_rs1),
    .u_rs2(u_rs2),
    .u_rd(u_rd),
    .u_wr(u_wr),
    .u_ready(u_ready),
    .timeout_count(timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  assign u_ready = modelReady | forceReady;

  // Single-precision <-> real helpers, valid for normal numbers and zero only.
  function automatic real sp2real(input logic [31:0] x);
    int e;
    logic [63:0] bits;
    if (x[30:0] == 31'd0) return 0.0;
    e = {24'd0, x[30:23]} - 127 + 1023;
    bits = {x[31], e[10:0], x[22:0], 29'd0};
    return $bitstoreal(bits);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = {21'd0, d[62:52]} - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpsubModel(input logic [31:0] a, input logic [31:0] b);
    return real2sp(sp2real(b) - sp2real(a));
  endfunction

  function automatic logic [31:0] mkInsn(input logic [6:0] f7, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, 3'b000, 5'd3, opc};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Unit stubs: ready fires lat cycles after the unit first sees its u_valid.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      modelReady[i] = 1'b0;
      if (u_valid[i] && !neverReady[i]) begin
        if (cnt[i] == lat[i]) modelReady[i] = 1'b1;
        cnt[i]++;
      end else begin
        cnt[i] = 0;
      end
      u_rd[32*i +: 32] = useFpsub[i] ? fpsubModel(u_rs1, u_rs2) : unitData[i];
      u_wr[i] = unitWr[i];
    end
  end

  // Scoreboard: every pcpi_ready must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (pcpi_ready) begin
      if (sbQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_ready: got pcpi_ready with rd=%h, required no ready", pcpi_rd);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_rd", pcpi_rd, e.rd);
        checkOutput("sb_wr", {31'd0, pcpi_wr}, {31'd0, e.wr});
        checkOutput("wait_with_ready", {31'd0, pcpi_wait}, 32'd0);
      end
    end else if (pcpi_wr) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL wr_without_ready: got pcpi_wr=1, required 0");
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {19'd0, pcpi_wr, pcpi_wait, pcpi_ready, u_valid, timeout_count}, 32'd0);
    checkOutput({tag, "_rd"}, pcpi_rd, 32'd0);
    checkOutput({tag, "_insn"}, u_insn, 32'd0);
    checkOutput({tag, "_rs1"}, u_rs1, 32'd0);
    checkOutput({tag, "_rs2"}, u_rs2, 32'd0);
  endtask

  // Called at a negedge; returns at a negedge with the hub back in IDLE.
  task automatic applyStimulus(input vec_t v);
    int c;
    int waitCycles;
    bit done;
    logic any;
    exp_t e;
    if (v.unit >= 0) begin
      lat[v.unit]      = v.lat;
      unitData[v.unit] = v.data;
      unitWr[v.unit]   = v.wr;
    end
    pcpi_insn  = v.insn;
    pcpi_rs1   = v.rs1;
    pcpi_rs2   = v.rs2;
    pcpi_valid = 1'b1;
    if (v.expMatch) begin
      e.rd = v.expRd;
      e.wr = v.expWr;
      sbQ.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("u_valid", {28'd0, u_valid}, v.expValid);
    if (v.expMatch) begin
      checkOutput("u_insn", u_insn, v.insn);
      checkOutput("u_rs1", u_rs1, v.rs1);
      checkOutput("u_rs2", u_rs2, v.rs2);
      c = 1;
      waitCycles = 0;
      done = 1'b0;
      while (c <= 200 && !done) begin
        if (pcpi_ready) begin
          done = 1'b1;
        end else begin
          if (pcpi_wait) waitCycles++;
          @(negedge clk);
          c++;
        end
      end
      checkOutput("latency", done ? c : 999, v.expLat);
      checkOutput("wait_cycles", waitCycles, v.expLat - 1);
    end else begin
      any = 1'b0;
      for (int k = 0; k < 20; k++) begin
        any = any | (|u_valid) | pcpi_wait | pcpi_ready;
        @(negedge clk);
      end
      checkOutput("ignored", {31'd0, any}, 32'd0);
    end
    pcpi_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic runTimeout(output int waitCycles, output bit sawReady);
    pcpi_insn  = mkInsn(7'h03, 7'h0B);
    pcpi_rs1   = 32'h1111_0000;
    pcpi_rs2   = 32'h2222_0000;
    pcpi_valid = 1'b1;
    waitCycles = 0;
    sawReady   = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (pcpi_ready) sawReady = 1'b1;
      if (pcpi_wait) waitCycles++;
      else break;
    end
    pcpi_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    int waitCycles;
    bit sawReady;
    bit anyReady;
    logic any;
    int c;
    bit done;
    exp_t e;

    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    pcpi_valid  = 1'b0;
    pcpi_insn   = '0;
    pcpi_rs1    = '0;
    pcpi_rs2    = '0;
    forceReady  = '0;
    modelReady  = '0;
    u_rd        = '0;
    u_wr        = '0;
    for (int i = 0; i < 4; i++) begin
      lat[i] = 0; cnt[i] = 0; unitData[i] = '0;
      unitWr[i] = 1'b1; neverReady[i] = 1'b0; useFpsub[i] = 1'b0;
    end
    useFpsub[1] = 1'b1;

    vecs[0] = '{mkInsn(7'h02, 7'h0B), 32'h4040_0000, 32'h3F80_0000, 1, 1, 32'h0, 1'b1,
                32'h2, 1'b1, 32'hC000_0000, 1'b1, 3};
    vecs[1] = '{mkInsn(7'h00, 7'h0B), 32'hAAAA_0001, 32'hBBBB_0002, 0, 3, 32'hDEAD_BEEF, 1'b1,
                32'h1, 1'b1, 32'hDEAD_BEEF, 1'b1, 5};
    vecs[2] = '{mkInsn(7'h03, 7'h0B), 32'h0000_0003, 32'h0000_0004, 3, 0, 32'h0BAD_F00D, 1'b0,
                32'h8, 1'b1, 32'h0BAD_F00D, 1'b0, 2};
    vecs[3] = '{mkInsn(7'h01, 7'h0B), 32'h7777_7777, 32'h8888_8888, 2, 7, 32'h55AA_55AA, 1'b1,
                32'h4, 1'b1, 32'h55AA_55AA, 1'b1, 9};
    vecs[4] = '{mkInsn(7'h00, 7'h0B), 32'h0000_0063, 32'h0000_0064, 0, 63, 32'h600D_CAFE, 1'b1,
                32'h1, 1'b1, 32'h600D_CAFE, 1'b1, 65};
    vecs[5] = '{mkInsn(7'h02, 7'b0110011), 32'h1, 32'h2, -1, 0, 32'h0, 1'b0,
                32'h0, 1'b0, 32'h0, 1'b0, 0};
    vecs[6] = '{mkInsn(7'h7F, 7'h0B), 32'h3, 32'h4, -1, 0, 32'h0, 1'b0,
                32'h0, 1'b0, 32'h0, 1'b0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);
    checkOutput("tcount_no_timeout", {24'd0, timeout_count}, 32'd0);

    neverReady[3] = 1'b1;
    runTimeout(waitCycles, sawReady);
    checkOutput("timeout_wait_cycles", waitCycles, 64);
    checkOutput("timeout_no_ready", {31'd0, sawReady}, 32'd0);
    checkOutput("timeout_count_1", {24'd0, timeout_count}, 32'd1);
    anyReady = 1'b0;
    for (int n = 1; n < 300; n++) begin
      runTimeout(waitCycles, sawReady);
      anyReady = anyReady | sawReady;
    end
    checkOutput("timeout_any_ready", {31'd0, anyReady}, 32'd0);
    checkOutput("timeout_count_sat", {24'd0, timeout_count}, 32'd255);
    neverReady[3] = 1'b0;

    $display("[TB] stray ready from unit 2 while unit 1 busy");
    useFpsub[1] = 1'b0;
    unitData[1] = 32'h1234_5678;
    lat[1]      = 4;
    unitData[2] = 32'hBAD2_BAD2;
    pcpi_insn   = mkInsn(7'h02, 7'h0B);
    pcpi_rs1    = 32'h0000_0101;
    pcpi_rs2    = 32'h0000_0202;
    pcpi_valid  = 1'b1;
    e.rd = 32'h1234_5678;
    e.wr = 1'b1;
    sbQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
    forceReady[2] = 1'b1;
    @(negedge clk);
    forceReady[2] = 1'b0;
    c = 2;
    done = 1'b0;
    while (c <= 200 && !done) begin
      if (pcpi_ready) done = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    checkOutput("stray_latency", done ? c : 999, 6);
    any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      any = any | (|u_valid) | pcpi_wait | pcpi_ready;
    end
    pcpi_valid = 1'b0;
    @(negedge clk);
    any = any | (|u_valid) | pcpi_wait | pcpi_ready;
    @(negedge clk);
    checkOutput("no_redispatch", {31'd0, any}, 32'd0);

    $display("[TB] reset during issue");
    lat[0]      = 4;
    unitData[0] = 32'hC0DE_0000;
    pcpi_insn   = mkInsn(7'h00, 7'h0B);
    pcpi_rs1    = 32'h0000_0A0A;
    pcpi_rs2    = 32'h0000_0B0B;
    pcpi_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("pre_reset_wait", {31'd0, pcpi_wait}, 32'd1);
    @(negedge clk);
    reset      = 1'b1;
    pcpi_valid = 1'b0;
    @(negedge clk);
    checkAllZero("midreset");
    reset = 1'b0;
    forceReady[0] = 1'b1;
    any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      forceReady[0] = 1'b0;
      any = any | pcpi_ready | pcpi_wait | (|u_valid);
    end
    checkOutput("stale_ready_ignored", {31'd0, any}, 32'd0);

    applyStimulus(vecs[1]);
    checkOutput("sb_drained", sbQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/picorv32_pcpi_fp_hub.md
# picorv32_pcpi_fp_hub

PCPI dispatch hub that sits between the picorv32 PCPI port and up to NUM_UNITS floating-point coprocessors (fpsub and its siblings). It decodes custom-0 R-type instructions by funct7 and forwards registered operands to exactly one unit. It holds the CPU in `pcpi_wait` while the unit works, then returns the unit's result to the CPU as a one-cycle `pcpi_ready`/`pcpi_wr` pulse. A timeout releases the CPU without `pcpi_ready` so a dead unit traps as an illegal instruction instead of hanging the core.

## Interface
- NUM_UNITS, 4, number of attached coprocessors (1..8)
- FUNCT7_LIST, {7'h03,7'h02,7'h01,7'h00}, packed NUM_UNITS×7 funct7 codes; unit i uses bits [7i+6:7i]; fpsub is 7'b0000010
- TIMEOUT, 64, max cycles in ISSUE before abort (≥2)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- pcpi_valid  in  1  CPU request valid
- pcpi_insn  in  32  instruction
- pcpi_rs1, pcpi_rs2  in  32 each  operands
- pcpi_wr  out  1  result write-enable (pulse with pcpi_ready)
- pcpi_rd  out  32  result
- pcpi_wait  out  1  hub busy on a claimed instruction
- pcpi_ready  out  1  result valid, one-cycle pulse
- u_valid  out  NUM_UNITS  one-hot request to unit i
- u_insn, u_rs1, u_rs2  out  32 each  registered broadcast of captured insn/operands
- u_rd  in  NUM_UNITS×32  unit results, unit i at [32i+31:32i]
- u_wr, u_ready  in  NUM_UNITS each  unit write-enable / ready
- timeout_count  out  8  saturating count of aborted dispatches

## Operation
- Match: pcpi_insn[6:0]==7'b0001011 and pcpi_insn[31:25] equals some FUNCT7_LIST entry; the lowest matching index wins. Instructions that do not match are ignored: no wait, no ready.
- IDLE: when pcpi_valid and match, capture insn/rs1/rs2 into u_* regs, set sel=index, u_valid[sel]=1, pcpi_wait=1, clear the timer, and go to ISSUE.
- ISSUE: hold u_valid[sel] and operands stable; increment the timer each cycle.
  - If u_ready[sel] is 1: latch pcpi_rd=u_rd[sel] and pcpi_wr=u_wr[sel], pulse pcpi_ready, drop u_valid and pcpi_wait, and go to RESP.
  - Else if the timer reaches TIMEOUT-1: drop u_valid and pcpi_wait, assert neither ready nor wr, increment timeout_count (saturating at 255), and go to DRAIN.
- RESP: pcpi_ready and pcpi_wr are high for exactly this one cycle; go to DRAIN.
- DRAIN: stay until pcpi_valid==0, then go to IDLE. This prevents a still-asserted pcpi_valid from re-dispatching the same instruction.
- u_ready/u_wr from unselected units, or received in any state other than ISSUE, are ignored.
- pcpi_rd keeps its last value outside RESP. Consumers qualify it with pcpi_ready.

## Timing
- Reset (synchronous, any state including mid-ISSUE): state=IDLE; pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, u_valid, u_insn, u_rs1, u_rs2, timeout_count, and the timer all 0. Units are reset separately. A unit result arriving after hub reset is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Edge E0 samples a matching pcpi_valid. From cycle E0+1, pcpi_wait and u_valid[sel] are high.
- Unit asserts u_ready[sel] in cycle Ek. The hub samples it at the end of Ek, and pcpi_ready/pcpi_wr/pcpi_rd are valid in cycle Ek+1.
- CPU-visible latency = unit latency + 2 cycles.
- pcpi_wait is high from E0+1 through Ek inclusive; it is never high in the same cycle as pcpi_ready.
- Timeout: with no u_ready, pcpi_wait falls after exactly TIMEOUT cycles of ISSUE. pcpi_ready stays 0.
- Minimum spacing between dispatches: 1 DRAIN cycle with pcpi_valid low.
- u_ready[sel] in the same cycle the timer hits TIMEOUT-1: the result wins (go to RESP, no timeout increment).

## Test plan
- fpsub on unit 1 (funct7 7'b0000010), pcpi_rs1=0x40400000, pcpi_rs2=0x3F800000 -> u_valid=4'b0010. fpsub computes rs2−rs1 = 1.0−3.0, so pcpi_rd=0xC0000000 with a one-cycle pcpi_ready&pcpi_wr. pcpi_wait falls the cycle ready rises.
- Stub unit 0 (funct7 0) returns 0xDEADBEEF on u_ready after 3 cycles -> pcpi_ready 5 cycles after the sampled pcpi_valid edge; pcpi_rd=0xDEADBEEF.
- Non-matching insn (opcode 0110011, or funct7 7'h7F) with pcpi_valid held 20 cycles -> u_valid, pcpi_wait, and pcpi_ready stay 0.
- Stub unit never readies, TIMEOUT=64 -> pcpi_wait high for exactly 64 cycles then 0, pcpi_ready never 1, timeout_count 0->1. Repeated 300 times, timeout_count saturates at 255.
- Unit 2 pulses u_ready while unit 1 is selected, then unit 1 readies with 0x12345678 -> only 0x12345678 is returned. pcpi_valid held high 3 cycles after ready -> no second dispatch.
- Reset asserted 2 cycles into ISSUE -> next cycle all outputs are 0 and state is IDLE. The stale unit ready that follows produces no pcpi_ready. A new request then dispatches normally.
